// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and masks register-file write data, counts retirements,
// and latches a sticky halt on HLT.
//   state  | meaning
//   RUN    | capturing instructions from MEM normally
//   HALTED | HLT retired; only bubbles load until rst
module mem_wb_stage #(
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] mem_data,
    input  logic [15:0] alu_result,
    input  logic [7:0]  imm8,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [1:0]  wb_op,
    input  logic [3:0]  dst_reg,
    input  logic        hlt,
    output logic [15:0] wb_data,
    output logic        wb_we,
    output logic [3:0]  wb_dst,
    output logic [15:0] wb_bytesel,
    output logic        wb_halt,
    output logic [15:0] retire_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] data_nxt, bytesel_nxt, cnt_nxt;
    logic        we_nxt;
    logic [3:0]  dst_nxt;

    logic [15:0] cap_data, cap_sel;
    logic        cap_we;

    always_comb begin
        cap_data = mem_to_reg ? mem_data : alu_result;
        cap_sel  = 16'hFFFF;
        case (wb_op)
            2'b01: begin
                cap_data = {8'h00, imm8};
                cap_sel  = 16'h00FF;
            end
            2'b10: begin
                cap_data = {imm8, 8'h00};
                cap_sel  = 16'hFF00;
            end
            default: ;
        endcase
        // HLT retires but never writes the register file
        cap_we = reg_write & ~hlt & ~(R0_HARDWIRED & (dst_reg == 4'h0));
    end

    always_comb begin
        state_nxt   = state;
        data_nxt    = wb_data;
        we_nxt      = wb_we;
        dst_nxt     = wb_dst;
        bytesel_nxt = wb_bytesel;
        cnt_nxt     = retire_cnt;
        if (flush || state == HALTED || (!stall && !in_valid)) begin
            data_nxt    = 16'h0000;
            we_nxt      = 1'b0;
            dst_nxt     = 4'h0;
            bytesel_nxt = 16'h0000;
        end else if (!stall) begin
            data_nxt    = cap_data;
            we_nxt      = cap_we;
            dst_nxt     = dst_reg;
            bytesel_nxt = cap_we ? cap_sel : 16'h0000;
            cnt_nxt     = retire_cnt + 16'd1;
            if (hlt) state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wb_data    <= 16'h0000;
            wb_we      <= 1'b0;
            wb_dst     <= 4'h0;
            wb_bytesel <= 16'h0000;
            retire_cnt <= 16'h0000;
        end else begin
            state      <= state_nxt;
            wb_data    <= data_nxt;
            wb_we      <= we_nxt;
            wb_dst     <= dst_nxt;
            wb_bytesel <= bytesel_nxt;
            retire_cnt <= cnt_nxt;
        end
    end

    assign wb_halt = (state == HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed expectations for write-back select,
// masking, stall/flush, halt and retire counter wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, mem_to_reg, reg_write, hlt;
    logic [15:0] mem_data, alu_result;
    logic [7:0]  imm8;
    logic [1:0]  wb_op;
    logic [3:0]  dst_reg;
    logic [15:0] wb_data, wb_bytesel, retire_cnt;
    logic        wb_we, wb_halt;
    logic [3:0]  wb_dst;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.R0_HARDWIRED(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .mem_data(mem_data), .alu_result(alu_result), .imm8(imm8),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .wb_op(wb_op),
        .dst_reg(dst_reg), .hlt(hlt), .wb_data(wb_data), .wb_we(wb_we),
        .wb_dst(wb_dst), .wb_bytesel(wb_bytesel), .wb_halt(wb_halt),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [3:0] dst,
                           input logic [15:0] data, input logic [15:0] sel,
                           input logic halt, input logic [15:0] cnt);
        chk({tag, ".we"},   {15'd0, wb_we},   {15'd0, we});
        chk({tag, ".dst"},  {12'd0, wb_dst},  {12'd0, dst});
        chk({tag, ".data"}, wb_data,          data);
        chk({tag, ".sel"},  wb_bytesel,       sel);
        chk({tag, ".halt"}, {15'd0, wb_halt}, {15'd0, halt});
        chk({tag, ".cnt"},  retire_cnt,       cnt);
    endtask

    task automatic instr(input logic v, input logic rw, input logic m2r, input logic [1:0] op,
                         input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] md,
                         input logic [7:0] imm, input logic h);
        in_valid = v; reg_write = rw; mem_to_reg = m2r; wb_op = op; dst_reg = dst;
        alu_result = alu; mem_data = md; imm8 = imm; hlt = h;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        instr(1'b1, 1'b1, 1'b0, 2'b00, 4'h7, 16'hDEAD, 16'hBEEF, 8'h55, 1'b1);
        step();
        chk_all("reset", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

        rst = 1'b0; stall = 1'b0;
        instr(1'b1, 1'b1, 1'b0, 2'b00, 4'h3, 16'h1234, 16'hBEEF, 8'h00, 1'b0);
        step();
        chk_all("add", 1'b1, 4'h3, 16'h1234, 16'hFFFF, 1'b0, 16'd1);

        instr(1'b1, 1'b1, 1'b1, 2'b10, 4'h5, 16'h1111, 16'h2222, 8'hAB, 1'b0);
        step();
        chk_all("lhb", 1'b1, 4'h5, 16'hAB00, 16'hFF00, 1'b0, 16'd2);

        instr(1'b1, 1'b1, 1'b1, 2'b01, 4'h6, 16'h1111, 16'h2222, 8'hCD, 1'b0);
        step();
        chk_all("llb", 1'b1, 4'h6, 16'h00CD, 16'h00FF, 1'b0, 16'd3);

        instr(1'b1, 1'b1, 1'b1, 2'b11, 4'h7, 16'h1111, 16'h5A5A, 8'h00, 1'b0);
        step();
        chk_all("op11_load", 1'b1, 4'h7, 16'h5A5A, 16'hFFFF, 1'b0, 16'd4);

        instr(1'b1, 1'b1, 1'b1, 2'b00, 4'h0, 16'h3333, 16'h4444, 8'h00, 1'b0);
        step();
        chk_all("load_r0", 1'b0, 4'h0, 16'h4444, 16'h0000, 1'b0, 16'd5);

        instr(1'b0, 1'b1, 1'b0, 2'b00, 4'h8, 16'h7777, 16'h0000, 8'h00, 1'b0);
        step();
        chk_all("bubble", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'd5);

        instr(1'b1, 1'b1, 1'b0, 2'b00, 4'h9, 16'h0F0F, 16'h0000, 8'h00, 1'b0);
        step();
        chk_all("add9", 1'b1, 4'h9, 16'h0F0F, 16'hFFFF, 1'b0, 16'd6);

        stall = 1'b1;
        instr(1'b1, 1'b1, 1'b0, 2'b01, 4'h2, 16'hFFFF, 16'h0000, 8'h99, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 1'b1, 4'h9, 16'h0F0F, 16'hFFFF, 1'b0, 16'd6);
        end

        flush = 1'b1;
        step();
        chk_all("stall_flush", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'd6);
        stall = 1'b0; flush = 1'b0;

        instr(1'b1, 1'b0, 1'b0, 2'b00, 4'hA, 16'h1357, 16'h0000, 8'h00, 1'b0);
        step();
        chk_all("no_regwrite", 1'b0, 4'hA, 16'h1357, 16'h0000, 1'b0, 16'd7);

        instr(1'b1, 1'b1, 1'b0, 2'b00, 4'h4, 16'h2468, 16'h0000, 8'h00, 1'b1);
        step();
        chk({"hlt", ".we"},   {15'd0, wb_we},   16'h0000);
        chk({"hlt", ".halt"}, {15'd0, wb_halt}, 16'h0001);
        chk({"hlt", ".cnt"},  retire_cnt,       16'd8);

        instr(1'b1, 1'b1, 1'b0, 2'b00, 4'h3, 16'h1234, 16'h0000, 8'h00, 1'b0);
        step();
        chk_all("halted_add", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 16'd8);
        stall = 1'b1;
        step();
        chk_all("halted_stall", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 16'd8);

        rst = 1'b1; flush = 1'b1;
        step();
        chk_all("rst_halted", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        step();
        chk_all("run_again", 1'b1, 4'h3, 16'h1234, 16'hFFFF, 1'b0, 16'd1);

        stall = 1'b1; rst = 1'b1;
        step();
        chk_all("rst_stall", 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        stall = 1'b0; rst = 1'b0;

        instr(1'b1, 1'b0, 1'b0, 2'b00, 4'h1, 16'h0000, 16'h0000, 8'h00, 1'b0);
        repeat (65535) step();
        chk("wrap.pre", retire_cnt, 16'hFFFF);
        step();
        chk("wrap.post", retire_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter R0_HARDWIRED, default 1; when 1, writes to register 0 are suppressed.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hold all stage state this cycle.
REQ-005 SHALL have port flush  input  1  load a bubble this cycle.
REQ-006 SHALL have port in_valid  input  1  MEM-stage instruction present.
REQ-007 SHALL have port mem_data  input  16  load data from data memory.
REQ-008 SHALL have port alu_result  input  16  ALU result.
REQ-009 SHALL have port imm8  input  8  LLB/LHB immediate.
REQ-010 SHALL have port mem_to_reg  input  1  select mem_data (1) or alu_result (0).
REQ-011 SHALL have port reg_write  input  1  instruction writes a register.
REQ-012 SHALL have port wb_op  input  2  00 full word, 01 LLB, 10 LHB, 11 treated as 00.
REQ-013 SHALL have port dst_reg  input  4  destination register index.
REQ-014 SHALL have port hlt  input  1  instruction is HLT.
REQ-015 SHALL have port wb_data  output  16  register-file write data (D).
REQ-016 SHALL have port wb_we  output  1  register-file write enable (WriteReg).
REQ-017 SHALL have port wb_dst  output  4  register-file write index.
REQ-018 SHALL have port wb_bytesel  output  16  per-bit write mask (bytesel).
REQ-019 SHALL have port wb_halt  output  1  sticky halt indication.
REQ-020 SHALL have port retire_cnt  output  16  count of retired valid instructions.

Function
REQ-021 SHALL register all outputs; outputs reflect inputs sampled on the previous rising edge (latency 1).
REQ-022 Per cycle, priority SHALL be: rst > flush > halted > stall > normal capture.
REQ-023 Normal capture with in_valid=1 SHALL load valid=1 and compute outputs from that cycle's inputs.
REQ-024 Normal capture with in_valid=0 SHALL load a bubble: wb_we=0, wb_bytesel=16'h0000, wb_data=16'h0000, wb_dst=4'h0.
REQ-025 wb_op=00/11 SHALL give wb_data = mem_to_reg ? mem_data : alu_result and wb_bytesel=16'hFFFF.
REQ-026 wb_op=01 (LLB) SHALL give wb_data={8'h00,imm8} and wb_bytesel=16'h00FF; mem_to_reg is ignored.
REQ-027 wb_op=10 (LHB) SHALL give wb_data={imm8,8'h00} and wb_bytesel=16'hFF00; mem_to_reg is ignored.
REQ-028 wb_we SHALL be valid & reg_write & ~(R0_HARDWIRED & dst_reg==0); when wb_we=0, wb_bytesel SHALL be 16'h0000.
REQ-029 stall=1 (no flush) SHALL hold every output and retire_cnt unchanged, including wb_we.
REQ-030 flush=1 SHALL load a bubble regardless of stall, in_valid or hlt; no retire or halt is recorded.
REQ-031 retire_cnt SHALL increment by 1 on each capture of a valid instruction (including HLT), wrapping 16'hFFFF -> 16'h0000.
REQ-032 Capture of a valid instruction with hlt=1 SHALL set wb_halt=1 in the same update; HLT itself SHALL produce wb_we=0.
REQ-033 Once wb_halt=1, the stage SHALL load only bubbles, ignore stall/in_valid, and freeze retire_cnt until rst.
REQ-034 State machine SHALL be RUN and HALTED; RUN->HALTED on valid HLT capture; HALTED->RUN only on rst.

Reset
REQ-035 rst=1 at a rising edge SHALL clear all outputs to 0, retire_cnt to 0, state to RUN, overriding stall, flush and in-flight data.
REQ-036 Reset asserted mid-stall or while HALTED SHALL take effect at the next edge identically.

Verification
REQ-037 Valid ADD, alu_result=16'h1234, dst=3, wb_op=00 -> next cycle wb_we=1, wb_dst=3, wb_data=16'h1234, wb_bytesel=16'hFFFF, retire_cnt=1.
REQ-038 LHB imm8=8'hAB, dst=5 -> wb_data=16'hAB00, wb_bytesel=16'hFF00; LLB imm8=8'hCD -> wb_data=16'h00CD, wb_bytesel=16'h00FF.
REQ-039 Valid load, mem_to_reg=1, dst=0 -> wb_we=0, wb_bytesel=0 (R0_HARDWIRED=1); retire_cnt increments.
REQ-040 Stall 3 cycles with new inputs -> outputs and retire_cnt unchanged; stall+flush together -> bubble next cycle.
REQ-041 Valid HLT then valid ADD inputs -> wb_halt=1, wb_we=0 thereafter, retire_cnt frozen; rst -> all zero, RUN.
REQ-042 Preload retire_cnt to 16'hFFFF via 65535 retirements, retire one more -> retire_cnt=16'h0000.
